// File: rtl/store_lane_buffer.sv
// Store lane buffer: formats SB/SH/SW requests into byte lanes plus byte enables,
// queues them in a DEPTH-entry FIFO and drains the FIFO to data memory over valid/ready.
// Latency: an accepted legal store is presented on mem_* from the next cycle. The
// req_* inputs have no combinational path to mem_*.
// Backpressure: req_ready = not full, and it depends on state only. Misaligned or
// illegal-size requests are dropped and flagged by a one-cycle misalign_err pulse.
// Ports: clk/rst; req_* store request in; mem_* write port out; misalign_err/err_addr
// report rejections; empty tells a fence that the buffer has drained.
module store_lane_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_data,
    input  logic [1:0]    req_size,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          misalign_err,
    output logic [AW-1:0] err_addr,
    output logic          empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } entry_t;

    entry_t        buf_q [DEPTH];
    entry_t        buf_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // Last popped entry. mem_* show it while the buffer is empty, so they keep
    // their last value instead of showing a stale slot.
    entry_t        hold_q, hold_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic   legal;
    entry_t fmt;
    logic   take, push, reject, pop;
    entry_t head;

    // Request legality and lane formatting
    always_comb begin
        legal     = 1'b0;
        fmt.addr  = {req_addr[AW-1:2], 2'b00};
        fmt.wdata = req_data;
        fmt.be    = 4'b0000;
        case (req_size)
            2'b00: begin
                legal     = 1'b1;
                fmt.wdata = {4{req_data[7:0]}};
                fmt.be    = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                legal     = ~req_addr[0];
                fmt.wdata = {2{req_data[15:0]}};
                fmt.be    = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal     = (req_addr[1:0] == 2'b00);
                fmt.wdata = req_data;
                fmt.be    = 4'b1111;
            end
            default: begin
                legal     = 1'b0;
                fmt.wdata = req_data;
                fmt.be    = 4'b0000;
            end
        endcase
    end

    assign req_ready = (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_valid = ~empty;

    assign take   = req_valid & req_ready;
    assign push   = take & legal;
    assign reject = take & ~legal;
    assign pop    = mem_valid & mem_ready;

    assign head      = empty ? hold_q : buf_q[rd_ptr_q];
    assign mem_addr  = head.addr;
    assign mem_wdata = head.wdata;
    assign mem_be    = head.be;

    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;

    always_comb begin
        buf_d      = buf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        err_d      = reject;
        err_addr_d = err_addr_q;

        if (reject) begin
            err_addr_d = req_addr;
        end
        if (push) begin
            buf_d[wr_ptr_q] = fmt;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            hold_d   = buf_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // A push and a pop in the same cycle leave the count unchanged
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            buf_q      <= buf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end
endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed bench for store_lane_buffer (DEPTH=4, AW=32).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_store_lane_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        misalign_err;
    logic [31:0] err_addr;
    logic        empty;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_lane_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .misalign_err(misalign_err), .err_addr(err_addr), .empty(empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] last_err;
    logic [31:0] exp_q [$];
    logic [31:0] a;

    task automatic drive_req(input logic [31:0] ad, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = ad;
        req_data  = d;
        req_size  = s;
    endtask

    initial begin
        vecs[0] = '{32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111};
        vecs[1] = '{32'h203, 32'h000000A5, 2'b00, 1'b0, 32'h200, 32'hA5A5A5A5, 4'b1000};
        vecs[2] = '{32'h202, 32'h00001234, 2'b01, 1'b0, 32'h200, 32'h12341234, 4'b1100};
        vecs[3] = '{32'h200, 32'h12345677, 2'b00, 1'b0, 32'h200, 32'h77777777, 4'b0001};
        vecs[4] = '{32'h300, 32'hABCDCAFE, 2'b01, 1'b0, 32'h300, 32'hCAFECAFE, 4'b0011};
        vecs[5] = '{32'h301, 32'h0000003C, 2'b00, 1'b0, 32'h300, 32'h3C3C3C3C, 4'b0010};
        vecs[6] = '{32'h000, 32'h11111111, 2'b11, 1'b1, 32'h0,   32'h0,        4'b0000};
        vecs[7] = '{32'h103, 32'h22222222, 2'b01, 1'b1, 32'h0,   32'h0,        4'b0000};
        vecs[8] = '{32'h002, 32'h33333333, 2'b10, 1'b1, 32'h0,   32'h0,        4'b0000};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        mem_ready = 1'b1;
        #12;
        check("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("rst_err", {31'b0, misalign_err}, 32'd0);
        check("rst_err_addr", err_addr, 32'h0);
        @(negedge clk); rst = 1'b0;
        last_err = 32'h0;

        // Table: one request at a time with the memory always ready
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_req(vecs[i].addr, vecs[i].data, vecs[i].size);
            @(negedge clk);
            req_valid = 1'b0;
            if (vecs[i].err) last_err = vecs[i].addr;
            check($sformatf("v%0d_mem_valid", i), {31'b0, mem_valid}, {31'b0, ~vecs[i].err});
            check($sformatf("v%0d_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_err_addr", i), err_addr, last_err);
            if (!vecs[i].err) begin
                check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_mem_be", i), {28'b0, mem_be}, {28'b0, vecs[i].exp_be});
            end
            @(negedge clk);
            check($sformatf("v%0d_empty_after", i), {31'b0, empty}, 32'd1);
            check($sformatf("v%0d_err_cleared", i), {31'b0, misalign_err}, 32'd0);
        end

        // Back-to-back rejections produce consecutive pulses
        @(negedge clk);
        drive_req(32'h101, 32'h0, 2'b01);
        @(negedge clk);
        drive_req(32'h102, 32'h0, 2'b10);
        check("b2b_err1", {31'b0, misalign_err}, 32'd1);
        check("b2b_addr1", err_addr, 32'h101);
        check("b2b_valid1", {31'b0, mem_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_err2", {31'b0, misalign_err}, 32'd1);
        check("b2b_addr2", err_addr, 32'h102);
        check("b2b_valid2", {31'b0, mem_valid}, 32'd0);
        @(negedge clk);
        check("b2b_err3", {31'b0, misalign_err}, 32'd0);
        check("b2b_addr_hold", err_addr, 32'h102);

        // Fill the buffer while memory stalls, then drain it
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fill_ready%0d", i), {31'b0, req_ready}, 32'd1);
            drive_req(32'h1000 + 32'(i * 16), 32'hC0DE0000 + 32'(i), 2'b10);
            @(negedge clk);
        end
        drive_req(32'h1040, 32'hC0DE0004, 2'b10);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("full_ready%0d", i), {31'b0, req_ready}, 32'd0);
            check($sformatf("stall_addr%0d", i), mem_addr, 32'h1000);
            check($sformatf("stall_wdata%0d", i), mem_wdata, 32'hC0DE0000);
            check($sformatf("stall_valid%0d", i), {31'b0, mem_valid}, 32'd1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        check("drain_ready_a", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("drain_ready_b", {31'b0, req_ready}, 32'd1);
        check("drain_head1", mem_addr, 32'h1010);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            check($sformatf("drain_head%0d", i), mem_addr, 32'h1000 + 32'(i * 16));
            check($sformatf("drain_wdata%0d", i), mem_wdata, 32'hC0DE0000 + 32'(i));
            @(negedge clk);
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        check("drain_valid", {31'b0, mem_valid}, 32'd0);

        // Continuous push/pop at count=2; the pointers wrap several times
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 32'h2000 + 32'(i * 4);
            drive_req(a, a, 2'b10);
            exp_q.push_back(a);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        for (int i = 2; i < 10; i++) begin
            a = 32'h2000 + 32'(i * 4);
            drive_req(a, a, 2'b10);
            check($sformatf("wrap_head%0d", i), mem_addr, exp_q[0]);
            check($sformatf("wrap_ready%0d", i), {31'b0, req_ready}, 32'd1);
            @(negedge clk);
            void'(exp_q.pop_front());
            exp_q.push_back(a);
            check($sformatf("wrap_nonempty%0d", i), {31'b0, empty}, 32'd0);
        end
        req_valid = 1'b0;
        while (exp_q.size() > 0) begin
            check("wrap_tail", mem_addr, exp_q[0]);
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        check("wrap_empty", {31'b0, empty}, 32'd1);

        // Asynchronous reset mid-cycle with three entries queued
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(32'h3000 + 32'(i * 4), 32'h5A5A0000, 2'b10);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("pre_rst_valid", {31'b0, mem_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, mem_valid}, 32'd0);
        check("arst_empty", {31'b0, empty}, 32'd1);
        check("arst_ready", {31'b0, req_ready}, 32'd1);
        check("arst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_valid%0d", i), {31'b0, mem_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/store_lane_buffer.md
Name: store_lane_buffer

Overview:
Store-side counterpart of the load sign/zero-extension path. It takes 32-bit store requests from the MEM stage (SB/SH/SW), narrows and replicates the data into byte lanes, and generates byte enables. Formatted writes are queued in a small FIFO and drained to data memory over a valid/ready handshake. Misaligned or illegal-size stores are rejected and reported as a one-cycle error pulse.

Parameters:
DEPTH, 4, number of buffered store entries (power of two, >=2)
AW, 32, address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  store request present
req_ready  output  1  buffer can accept a request (= not full)
req_addr  input  AW  byte address of the store
req_data  input  32  register value to store (low bits used for SB/SH)
req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
mem_valid  output  1  head entry presented to memory
mem_ready  input  1  memory accepts the head entry
mem_addr  output  AW  word-aligned address {req_addr[AW-1:2],2'b00}
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
misalign_err  output  1  one-cycle pulse: request rejected
err_addr  output  AW  address of the most recent rejected request
empty  output  1  no entries buffered (used for fence/drain)

Behaviour:
- Reset (async, rst=1): rd/wr pointers and count cleared. mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, err_addr=0, empty=1, req_ready=1. Reset mid-operation discards all queued entries; no partial write is presented after reset.
- Handshake: a request is taken at a rising edge with req_valid&&req_ready. req_ready=(count!=DEPTH) is combinational from state only and never depends on req_valid.
- Legality: byte is always legal. Half is legal iff addr[0]=0. Word is legal iff addr[1:0]=00. size=11 is always illegal.
- Illegal accepted request: not enqueued; count unchanged. Next cycle misalign_err=1 for exactly one cycle and err_addr=req_addr. err_addr holds until the next rejection. Back-to-back rejections give consecutive pulses.
- Formatting of legal requests:
  - byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{data[15:0]}}, be=addr[1]?4'b1100:4'b0011
  - word: wdata=data, be=4'b1111
- Queue: FIFO order is strict. Entry = {mem_addr, wdata, be}. Pointers wrap modulo DEPTH.
- Drain: mem_valid=!empty. mem_addr/mem_wdata/mem_be show the head entry and stay stable while mem_valid&&!mem_ready. Pop on mem_valid&&mem_ready.
- Latency: a legal request accepted at edge N into an empty buffer gives mem_valid=1 from edge N (visible in cycle N+1). There is no combinational bypass from req_* to mem_*.
- Simultaneous push and pop: when not full, both occur and count is unchanged. When full, req_ready=0, so a same-cycle pop does not admit a push; the push is admitted the following cycle.
- Empty: mem_valid=0. When mem_valid=0, mem_addr/mem_wdata/mem_be retain their last value (don't-care for the consumer).
- count width is clog2(DEPTH)+1 and never exceeds DEPTH or underflows.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF with mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111; empty=1 after the pop.
- SB addr=0x203 data=0x000000A5 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_be=1000. SH addr=0x202 data=0x1234 -> wdata=0x12341234, be=1100.
- SH addr=0x101 and SW addr=0x102 back-to-back -> two consecutive misalign_err pulses, err_addr=0x101 then 0x102, no mem_valid. size=11 at addr=0x0 -> also rejected.
- mem_ready=0 while pushing 5 legal stores with DEPTH=4 -> req_ready drops after the 4th. Then mem_ready=1 -> entries drain in order, 5th accepted the cycle after the first pop, outputs stable while stalled.
- Continuous push with mem_ready=1 at count=2 -> count stays 2 across simultaneous push/pop; the pointers wrap past DEPTH-1 with order preserved.
- rst asserted asynchronously mid-cycle with 3 entries queued -> mem_valid=0 and empty=1 immediately, and no stale entry appears after rst deasserts.
